// File: rtl/ifu_fetch.sv
// -----------------------------------------------------------------------------
// ifu_fetch -- instruction-fetch stage feeding the decoder.
//
// Owns the fetch PC (fpc) and issues word reads to instruction memory over a
// req/ack handshake. Returned words are buffered together with their PCs in a
// small FIFO, and the FIFO head is presented to the decoder as pc/inst. A
// decoder redirect (jCe/jAddr), taken only when the head is consumed, flushes
// every wrong-path fetch.
//
// Parameters:
//   RESET_PC    fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous, active-high reset
//   imem_req    fetch request (combinational)
//   imem_addr   fetch word address, low 2 bits always 0
//   imem_ack    request accepted, imem_rdata valid this cycle
//   imem_rdata  fetched instruction word
//   stall       decoder not accepting this cycle
//   jCe         redirect request from the decoder
//   jAddr       redirect target
//   inst_valid  pc/inst hold a valid instruction
//   pc          address of the presented instruction (0 when empty)
//   inst        presented instruction word (0 when empty)
//
// Optional feature, macro IFU_PERF_CNT_EN:
//   fetch_cnt   instructions popped by the decoder (wraps)
//   bubble_cnt  active, non-stalled cycles with nothing to present (wraps)
// -----------------------------------------------------------------------------
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jCe,
  input  logic [31:0] jAddr,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] inst
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DISCARD
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [31:0]        stale_q, stale_d;   // address of the wrong-path request still in flight
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]        fifo_inst_q [FIFO_DEPTH];

  logic               pop;
  logic               redirect;
  logic               push;
  logic               flush;

  // Presentation: the FIFO head, forced to a nop at address 0 while empty.
  assign inst_valid = (count_q != '0);
  assign pc         = inst_valid ? fifo_pc_q[head_q]   : 32'h0;
  assign inst       = inst_valid ? fifo_inst_q[head_q] : 32'h0;

  assign pop      = inst_valid && !stall;
  // The jump itself is consumed by this pop; a stalled or empty head never redirects.
  assign redirect = pop && jCe;

  // ---------------------------------------------------------------------------
  // Next-state, handshake and FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    fpc_d     = fpc_q;
    stale_d   = stale_q;
    imem_req  = 1'b0;
    imem_addr = fpc_q;
    push      = 1'b0;
    flush     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        // A same-cycle pop frees a slot, so a full FIFO may still request.
        imem_req = (count_q < DEPTH_C) || pop;
        if (redirect) begin
          flush = 1'b1;
          fpc_d = jAddr & 32'hFFFF_FFFC;
          // A request left hanging must still complete; its data is wrong-path.
          if (imem_req && !imem_ack) begin
            state_d = S_DISCARD;
            stale_d = fpc_q;
          end
        end else if (imem_req && imem_ack) begin
          push  = 1'b1;
          fpc_d = fpc_q + 32'd4;
        end
      end

      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = stale_q;
        if (redirect) begin
          flush = 1'b1;
          fpc_d = jAddr & 32'hFFFF_FFFC;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
      stale_q <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      stale_q <= stale_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; count_q gates every
  // read, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[tail_q]   <= fpc_q;
      fifo_inst_q[tail_q] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      if (pop) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q != S_IDLE) && !stall && !inst_valid) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
